divider_32: RTL

DIVIDER_32 -- requirements
Module: divider_32

---
 rtl/divider_32.sv | 122 ++++++++++++
 1 files changed

// File: rtl/divider_32.sv
// 32-bit radix-2 restoring divider, signed or unsigned, one quotient bit per cycle.
// Valid/ready on both sides; results are registered and held until consumed.
module divider_32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        sign,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q;
  logic [5:0]  cnt_q;
  logic [31:0] dvd_q;       // dividend bits shift out of the top, quotient bits in at the bottom
  logic [31:0] dvs_q;
  logic [31:0] rem_q;
  logic [31:0] src1_q;
  logic        neg_quo_q;
  logic        neg_rem_q;
  logic        div0_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [31:0] quotient_q;
  logic [31:0] remainder_q;

  logic [31:0] abs1;
  logic [31:0] abs2;
  logic [32:0] pr_d;
  logic        ge_d;
  logic [31:0] diff_d;
  logic [31:0] rem_d;
  logic [31:0] dvd_d;
  logic [31:0] quo_fix_d;
  logic [31:0] rem_fix_d;

  always_comb begin
    abs1 = (sign && src1[31]) ? (~src1 + 32'd1) : src1;
    abs2 = (sign && src2[31]) ? (~src2 + 32'd1) : src2;

    pr_d   = {rem_q, dvd_q[31]};
    ge_d   = pr_d[32] || (pr_d[31:0] >= dvs_q);
    // When the compare succeeds the true difference fits in 32 bits, so wraparound is harmless.
    diff_d = pr_d[31:0] - dvs_q;
    rem_d  = ge_d ? diff_d : pr_d[31:0];
    dvd_d  = {dvd_q[30:0], ge_d};

    // A zero divisor bypasses sign fixup: the natural all-ones quotient would otherwise be negated.
    quo_fix_d = div0_q ? 32'hFFFF_FFFF : (neg_quo_q ? (~dvd_d + 32'd1) : dvd_d);
    rem_fix_d = div0_q ? src1_q        : (neg_rem_q ? (~rem_d + 32'd1) : rem_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 6'd0;
      dvd_q       <= 32'd0;
      dvs_q       <= 32'd0;
      rem_q       <= 32'd0;
      src1_q      <= 32'd0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      div0_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quotient_q  <= 32'd0;
      remainder_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            dvd_q      <= abs1;
            dvs_q      <= abs2;
            rem_q      <= 32'd0;
            src1_q     <= src1;
            cnt_q      <= 6'd0;
            neg_quo_q  <= sign && (src1[31] ^ src2[31]);
            neg_rem_q  <= sign && src1[31];
            div0_q     <= (src2 == 32'd0);
            in_ready_q <= 1'b0;
            state_q    <= CALC;
          end
        end
        CALC: begin
          dvd_q <= dvd_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            quotient_q  <= quo_fix_d;
            remainder_q <= rem_fix_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule
